// File: rtl/fwd_scoreboard.sv
// Hazard-detection and operand-forwarding scoreboard: tracks issued writers per pipeline entry,
// forwards the youngest available result per read port and stalls decode on unready operands.
module fwd_scoreboard #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned RPORTS      = 2,
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned ALU_LAT     = 1,
    parameter int unsigned LOAD_LAT    = 2,
    parameter int unsigned FLUSH_DEPTH = 0,
    parameter int unsigned CW          = 16
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          advance,
    input  logic                          flush,
    input  logic                          issue_valid,
    input  logic                          issue_wen,
    input  logic                          issue_load,
    input  logic [AW-1:0]                 issue_wsel,
    input  logic [RPORTS-1:0][AW-1:0]     rsel,
    input  logic [RPORTS-1:0]             rused,
    input  logic [RPORTS-1:0][DW-1:0]     rf_rdat,
    input  logic [STAGES-1:0][DW-1:0]     stage_data,
    output logic [RPORTS-1:0][DW-1:0]     fwd_data,
    output logic [RPORTS-1:0]             fwd_hit,
    output logic                          stall,
    output logic [CW-1:0]                 stall_cnt
);

    logic [STAGES-1:0]         r_v;
    logic [STAGES-1:0]         r_wen;
    logic [STAGES-1:0]         r_load;
    logic [STAGES-1:0][AW-1:0] r_wsel;
    logic [CW-1:0]             r_stall_cnt;

    logic [RPORTS-1:0]         w_found;
    logic [RPORTS-1:0]         w_avail;
    logic [RPORTS-1:0][DW-1:0] w_dat;
    logic [STAGES-1:0]         w_kill;
    logic [STAGES-1:0]         w_vkept;
    logic                      w_stall;
    logic                      w_acc;

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        w_found = '0;
        w_avail = '0;
        w_dat   = '0;
        for (int p = 0; p < int'(RPORTS); p++) begin
            for (int i = int'(STAGES) - 1; i >= 0; i--) begin
                if (r_v[i] && r_wen[i] && (r_wsel[i] == rsel[p]) && (rsel[p] != '0)) begin
                    w_found[p] = 1'b1;
                    w_avail[p] = (i >= (r_load[i] ? int'(LOAD_LAT) : int'(ALU_LAT)));
                    w_dat[p]   = stage_data[i];
                end
            end
        end
    end

    always_comb begin
        fwd_data = rf_rdat;
        fwd_hit  = '0;
        for (int p = 0; p < int'(RPORTS); p++) begin
            if (w_found[p] && w_avail[p]) begin
                fwd_data[p] = w_dat[p];
                fwd_hit[p]  = 1'b1;
            end
        end
    end

    always_comb begin
        w_kill = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_kill[i] = flush && (i < int'(FLUSH_DEPTH));
        end
    end

    assign w_vkept   = r_v & ~w_kill;
    assign w_stall   = issue_valid && (|(rused & w_found & ~w_avail));
    assign w_acc     = advance && issue_valid && !w_stall && !flush;
    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_v         <= '0;
            r_wen       <= '0;
            r_load      <= '0;
            r_wsel      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (advance) begin
                for (int i = 1; i < int'(STAGES); i++) begin
                    r_v[i]    <= w_vkept[i-1];
                    r_wen[i]  <= r_wen[i-1];
                    r_load[i] <= r_load[i-1];
                    r_wsel[i] <= r_wsel[i-1];
                end
                r_v[0]    <= w_acc;
                r_wen[0]  <= issue_wen;
                r_load[0] <= issue_load;
                r_wsel[0] <= issue_wsel;
            end else begin
                // Flush without a shift clears the young entries in place.
                r_v <= w_vkept;
            end
            if (advance && w_stall && (r_stall_cnt != {CW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios then random traffic, checked against a
// producer-age list model.
module tb_fwd_scoreboard;

    localparam int STAGES      = 3;
    localparam int RPORTS      = 2;
    localparam int DW          = 32;
    localparam int AW          = 5;
    localparam int ALU_LAT     = 1;
    localparam int LOAD_LAT    = 2;
    localparam int FLUSH_DEPTH = 1;
    localparam int CW          = 2;

    logic                      CLK = 1'b0;
    logic                      nRST;
    logic                      advance, flush, issue_valid, issue_wen, issue_load;
    logic [AW-1:0]             issue_wsel;
    logic [RPORTS-1:0][AW-1:0] rsel;
    logic [RPORTS-1:0]         rused;
    logic [RPORTS-1:0][DW-1:0] rf_rdat;
    logic [STAGES-1:0][DW-1:0] stage_data;
    logic [RPORTS-1:0][DW-1:0] fwd_data;
    logic [RPORTS-1:0]         fwd_hit;
    logic                      stall;
    logic [CW-1:0]             stall_cnt;

    int total = 0;
    int bad   = 0;

    fwd_scoreboard #(
        .STAGES(STAGES), .RPORTS(RPORTS), .DW(DW), .AW(AW), .ALU_LAT(ALU_LAT),
        .LOAD_LAT(LOAD_LAT), .FLUSH_DEPTH(FLUSH_DEPTH), .CW(CW)
    ) dut (
        .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_load(issue_load),
        .issue_wsel(issue_wsel), .rsel(rsel), .rused(rused), .rf_rdat(rf_rdat),
        .stage_data(stage_data), .fwd_data(fwd_data), .fwd_hit(fwd_hit),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Model: every live producer with its age in advances since acceptance.
    typedef struct {
        int            age;
        bit            wen;
        bit            load;
        logic [AW-1:0] wsel;
    } prod_t;

    prod_t q[$];
    int    m_cnt = 0;

    function automatic void model_port(input int p, output logic hit, output logic [DW-1:0] dat,
                                       output logic need);
        int best = -1;
        foreach (q[k]) begin
            if (q[k].wen && q[k].wsel == rsel[p] && rsel[p] != 0 &&
                (best < 0 || q[k].age < q[best].age)) best = k;
        end
        hit  = 1'b0;
        dat  = rf_rdat[p];
        need = 1'b0;
        if (best >= 0) begin
            if (q[best].age >= (q[best].load ? LOAD_LAT : ALU_LAT)) begin
                hit = 1'b1;
                dat = stage_data[q[best].age];
            end else begin
                need = 1'b1;
            end
        end
    endfunction

    function automatic logic model_stall();
        logic h, n, s;
        logic [DW-1:0] d;
        s = 1'b0;
        for (int p = 0; p < RPORTS; p++) begin
            model_port(p, h, d, n);
            if (rused[p] && n) s = 1'b1;
        end
        return s && issue_valid;
    endfunction

    task automatic model_edge();
        logic s;
        prod_t e;
        s = model_stall();
        if (!nRST) begin
            q.delete();
            m_cnt = 0;
            return;
        end
        if (flush) begin
            for (int k = q.size() - 1; k >= 0; k--) if (q[k].age < FLUSH_DEPTH) q.delete(k);
        end
        if (advance) begin
            if (s && m_cnt < (1 << CW) - 1) m_cnt++;
            foreach (q[k]) q[k].age++;
            for (int k = q.size() - 1; k >= 0; k--) if (q[k].age >= STAGES) q.delete(k);
            if (issue_valid && !s && !flush) begin
                e.age = 0; e.wen = issue_wen; e.load = issue_load; e.wsel = issue_wsel;
                q.push_back(e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic h, n;
        logic [DW-1:0] d;
        for (int p = 0; p < RPORTS; p++) begin
            model_port(p, h, d, n);
            chk($sformatf("fwd_data[%0d]", p), fwd_data[p], d);
            chk($sformatf("fwd_hit[%0d]", p), {31'd0, fwd_hit[p]}, {31'd0, h});
        end
        chk("stall", {31'd0, stall}, {31'd0, model_stall()});
        chk("stall_cnt", {30'd0, stall_cnt}, m_cnt);
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic edge_();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        advance = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_wen = 1'b0;
        issue_load = 1'b0; issue_wsel = '0; rsel = '0; rused = '0;
    endtask

    task automatic issue(input logic wen, input logic load, input logic [AW-1:0] wsel);
        issue_valid = 1'b1; issue_wen = wen; issue_load = load; issue_wsel = wsel;
    endtask

    task automatic reset_pulse();
        nRST = 1'b0;
        idle();
        settle();
        edge_();
        nRST = 1'b1;
    endtask

    initial begin
        idle();
        rf_rdat    = {32'h0000_5555, 32'h0000_4444};
        stage_data = {32'h0000_00BB, 32'h0000_00AA, 32'h0000_0100};

        // Reset held with a live decode slot.
        nRST = 1'b0;
        issue(1'b1, 1'b0, 5'd3);
        rsel  = {5'd3, 5'd3};
        rused = 2'b11;
        edge_();
        edge_();
        settle();
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_hit", {30'd0, fwd_hit}, 0);
        chk("rst_data0", fwd_data[0], 32'h0000_4444);
        chk("rst_cnt", {30'd0, stall_cnt}, 0);
        edge_();
        nRST = 1'b1;

        // ALU producer then dependent consumer: one stall.
        idle();
        issue(1'b1, 1'b0, 5'd3);
        settle(); edge_();
        issue(1'b1, 1'b0, 5'd7);
        rsel[0] = 5'd3; rused = 2'b01;
        settle(); chk("alu_stall", {31'd0, stall}, 1); edge_();
        settle();
        chk("alu_stall_rel", {31'd0, stall}, 0);
        chk("alu_hit", {31'd0, fwd_hit[0]}, 1);
        chk("alu_fwd", fwd_data[0], 32'h0000_00AA);
        edge_();

        // Load producer: two stalls.
        reset_pulse();
        issue(1'b1, 1'b1, 5'd4);
        settle(); edge_();
        issue(1'b1, 1'b0, 5'd7);
        rsel[1] = 5'd4; rused = 2'b10;
        settle(); chk("ld_stall1", {31'd0, stall}, 1); edge_();
        settle(); chk("ld_stall2", {31'd0, stall}, 1); edge_();
        settle();
        chk("ld_rel", {31'd0, stall}, 0);
        chk("ld_cnt", {30'd0, stall_cnt}, 2);
        chk("ld_fwd", fwd_data[1], 32'h0000_00BB);
        edge_();

        // Youngest match wins, even when it is not yet available.
        stage_data[1] = 32'h0000_0022;
        stage_data[2] = 32'h0000_0011;
        idle();
        issue(1'b1, 1'b0, 5'd5);
        settle(); edge_();
        settle(); edge_();
        issue_valid = 1'b0;
        rsel[0] = 5'd5; rused = 2'b01;
        settle(); chk("young_hidden", {31'd0, fwd_hit[0]}, 0); edge_();
        settle(); chk("young_fwd", fwd_data[0], 32'h0000_0022); edge_();

        // Writes to r0 never match.
        idle();
        issue(1'b1, 1'b0, 5'd0);
        settle(); edge_();
        issue(1'b1, 1'b0, 5'd7);
        rsel[0] = 5'd0; rused = 2'b01;
        settle();
        chk("r0_hit", {30'd0, fwd_hit}, 0);
        chk("r0_stall", {31'd0, stall}, 0);
        edge_();

        // Flush with advance drops entry 0 and the decode instruction.
        reset_pulse();
        issue(1'b1, 1'b0, 5'd6);
        settle(); edge_();
        issue(1'b1, 1'b0, 5'd9);
        flush = 1'b1;
        settle(); edge_();
        flush = 1'b0;
        issue(1'b1, 1'b0, 5'd7);
        rsel = {5'd9, 5'd6}; rused = 2'b11;
        settle();
        chk("fl_stall", {31'd0, stall}, 0);
        chk("fl_hit", {30'd0, fwd_hit}, 0);
        edge_();

        // Hold with advance=0, then counter saturation.
        reset_pulse();
        issue(1'b1, 1'b1, 5'd4);
        settle(); edge_();
        issue(1'b1, 1'b0, 5'd7);
        rsel[0] = 5'd4; rused = 2'b01;
        advance = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("hold_stall", {31'd0, stall}, 1);
            chk("hold_cnt", {30'd0, stall_cnt}, 0);
            edge_();
        end
        advance = 1'b1;
        settle(); edge_();
        settle(); chk("sat_cnt1", {30'd0, stall_cnt}, 1); edge_();
        issue(1'b1, 1'b1, 5'd8);
        settle(); chk("sat_cnt2", {30'd0, stall_cnt}, 2); edge_();
        issue(1'b1, 1'b0, 5'd7);
        rsel[0] = 5'd8;
        settle(); chk("sat_stall", {31'd0, stall}, 1); edge_();
        settle(); chk("sat_cnt3", {30'd0, stall_cnt}, 3); edge_();
        settle(); chk("sat_cnt3b", {30'd0, stall_cnt}, 3); edge_();

        // Random traffic against the model.
        reset_pulse();
        for (int c = 0; c < 400; c++) begin
            nRST        = ($urandom_range(0, 99) >= 3);
            advance     = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            issue_valid = ($urandom_range(0, 4) != 0);
            issue_wen   = ($urandom_range(0, 3) != 0);
            issue_load  = ($urandom_range(0, 2) == 0);
            issue_wsel  = AW'($urandom_range(0, 7));
            for (int p = 0; p < RPORTS; p++) begin
                rsel[p]    = AW'($urandom_range(0, 7));
                rused[p]   = $urandom_range(0, 1);
                rf_rdat[p] = $urandom;
            end
            for (int s = 0; s < STAGES; s++) stage_data[s] = $urandom;
            settle();
            edge_();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard-detection and operand-forwarding scoreboard for the in-order pipelined datapath. It generalises the fixed EX/MEM/WB forwarding and load-use stall logic to:
- any number of in-flight stages;
- any number of read ports;
- per-class result latency (ALU vs load);
- configurable flush depth.

It sits beside the decode stage: it tracks every issued register writer, muxes the youngest available value onto each read port, and raises `stall` when a needed value is not yet produced.

## Interface
- `STAGES`, default 3: tracked entries after issue; entry 0 is the youngest (EX), entry STAGES-1 the oldest (WB).
- `RPORTS`, default 2: operand read ports.
- `DW`, default 32: data width.
- `AW`, default 5: register-select width; register 0 is hardwired zero.
- `ALU_LAT`, default 1: lowest entry index at which a non-load result is valid on `stage_data`.
- `LOAD_LAT`, default 2: lowest entry index at which a load result is valid; LOAD_LAT ≥ ALU_LAT and LOAD_LAT < STAGES.
- `FLUSH_DEPTH`, default 0: already-issued entries (indices 0..FLUSH_DEPTH-1) killed by `flush`.
- `CW`, default 16: stall-counter width.

Ports (name, direction, width, meaning):
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `advance` in 1: the pipeline moves this cycle (the datapath's ihit/dhit enable).
- `flush` in 1: branch/jump squash.
- `issue_valid` in 1: the decode slot holds an instruction.
- `issue_wen` in 1: that instruction writes a register.
- `issue_load` in 1: that instruction is a load.
- `issue_wsel` in AW: its destination register.
- `rsel` in RPORTS×AW: source register per port.
- `rused` in RPORTS: the port is actually read by the instruction.
- `rf_rdat` in RPORTS×DW: register-file read data.
- `stage_data` in STAGES×DW: result value currently held at each entry.
- `fwd_data` out RPORTS×DW: operand after forwarding.
- `fwd_hit` out RPORTS: the port took a forwarded value.
- `stall` out 1: hold decode and fetch; bubble into entry 0.
- `stall_cnt` out CW: saturating count of stalled advances.

## Operation
- **Entry state:** each entry holds {`v`, `wen`, `load`, `wsel`}. An entry "writes r" when `v && wen && wsel==r && r!=0`.
- **Read match, per port p:**
  - Find the lowest index i whose entry writes `rsel[p]`.
  - None found: `fwd_data[p]=rf_rdat[p]`, `fwd_hit[p]=0`.
  - Found: the value is available if i ≥ (`load[i]` ? LOAD_LAT : ALU_LAT).
  - Available: `fwd_data[p]=stage_data[i]`, `fwd_hit[p]=1`.
  - Not available: `fwd_data[p]=rf_rdat[p]`, `fwd_hit[p]=0`.
  - Only the youngest match is considered; an older available match never hides a younger unavailable one.
- **Stall:** `stall` = OR over p of (`rused[p]` && match found && not available) && `issue_valid`. It is independent of `advance`.
- **Issue accept:** `acc` = `advance && issue_valid && !stall && !flush`.
- **Update on advance=1:**
  - entry[i] ← entry[i-1] for i ≥ 1.
  - entry[0] ← {1, `issue_wen`, `issue_load`, `issue_wsel`} if `acc`, else a bubble (v=0).
  - The oldest entry retires.
- **advance=0:** entries hold.
- **Flush:** applied to pre-shift state; entries 0..FLUSH_DEPTH-1 are invalidated.
  - With `advance`, they shift as bubbles.
  - Without `advance`, they clear in place.
  - The decode instruction is never accepted.
- **Stall counter:** `stall_cnt` increments when `advance && stall`, saturating at 2^CW−1.
- **Reset (nRST=0 at a rising edge):** all `v`=0 and `stall_cnt`=0. The result after reset is `stall`=0, `fwd_hit`=0, and `fwd_data`=`rf_rdat`. Reset overrides advance and flush.

## Timing
- `fwd_data`, `fwd_hit`, `stall`: combinational from current state plus same-cycle inputs, with zero latency.
- State and `stall_cnt` update on the rising edge only.
- A producer accepted at edge k is visible to matching from cycle k+1. Its value forwards once its index reaches its latency (ALU_LAT or LOAD_LAT advances later).
- With defaults:
  - Dependent ALU op directly after an ALU op: 1 stall.
  - Dependent op directly after a load: 2 stalls.
- Stall is released in the cycle the producer's entry reaches its latency index.
- Mid-operation reset discards all tracking; no partial state survives.
- advance=0 with stall=1: no bubble, no count.

## Test plan
- **Reset:** hold nRST=0 for 2 cycles with `issue_valid`=1 → `stall`=0, `fwd_hit`=00, `fwd_data`=`rf_rdat`, `stall_cnt`=0.
- **ALU use:** issue add r3; next cycle `rsel[0]`=3, `rused`=01 → `stall`=1 for 1 cycle; then `fwd_hit[0]`=1 with `fwd_data[0]`=`stage_data[1]`=0x0000_00AA.
- **Load use:** issue lw r4; consumer reads r4 on port 1 → 2 stalls, `stall_cnt`=2, then `fwd_data[1]`=`stage_data[2]`.
- **Youngest wins / r0:**
  - Issue r5←0x11, then r5←0x22; after both are available, the port returns 0x22.
  - Any write to r0 never matches: `fwd_hit`=0.
- **Flush:** FLUSH_DEPTH=1, issue r6 then `flush`=1 with `advance` → the r6 entry and the decode instruction are dropped; a consumer of r6 sees `stall`=0 and `fwd_hit`=0.
- **Hold and saturation:** CW=2 with a sustained stall and `advance`=1 → `stall_cnt` goes 1,2,3,3. `advance`=0 for 5 cycles → entries and counter unchanged.
